// File: rtl/instr_loader.sv
// Instruction loader: assembles big-endian 32-bit words from a UART byte
// stream and writes them to instruction memory until the halt marker or the
// end of memory, then raises start to release the core.
module instr_loader #(
    parameter int unsigned         len_addr  = 32,
    parameter int unsigned         len_data  = 32,
    parameter int unsigned         MAX_WORDS = 1024,
    parameter logic [len_data-1:0] HALT_WORD = 32'hFFFF_FFFF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                load_req,
    input  logic [7:0]          rx_data,
    input  logic                rx_valid,
    output logic                mem_we,
    output logic [len_addr-1:0] mem_addr,
    output logic [len_data-1:0] mem_wdata,
    output logic                start,
    output logic                busy,
    output logic                overflow,
    output logic                drop_err
);

    typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;

    localparam logic [len_addr-1:0] LAST_ADDR = len_addr'(MAX_WORDS - 1);

    state_t              state, state_nx;
    logic [1:0]          byte_cnt, byte_cnt_nx;
    logic [len_data-1:0] word, word_nx;
    logic [len_data-1:0] shifted;
    logic                mem_we_nx, start_nx, busy_nx, overflow_nx, drop_err_nx;
    logic [len_addr-1:0] mem_addr_nx;
    logic [len_data-1:0] mem_wdata_nx;

    // Incoming byte lands in the low byte; earlier bytes move toward the MSB.
    assign shifted = {word[len_data-9:0], rx_data};

    // State and registered outputs; reset wins over every other input.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            byte_cnt  <= '0;
            word      <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            start     <= 1'b0;
            busy      <= 1'b0;
            overflow  <= 1'b0;
            drop_err  <= 1'b0;
        end else begin
            state     <= state_nx;
            byte_cnt  <= byte_cnt_nx;
            word      <= word_nx;
            mem_we    <= mem_we_nx;
            mem_addr  <= mem_addr_nx;
            mem_wdata <= mem_wdata_nx;
            start     <= start_nx;
            busy      <= busy_nx;
            overflow  <= overflow_nx;
            drop_err  <= drop_err_nx;
        end
    end

    // Next-state and next-output logic; outputs are computed one cycle ahead
    // so the registered values line up with the state being entered.
    always_comb begin
        state_nx     = state;
        byte_cnt_nx  = byte_cnt;
        word_nx      = word;
        mem_we_nx    = 1'b0;
        mem_addr_nx  = mem_addr;
        mem_wdata_nx = mem_wdata;
        start_nx     = start;
        busy_nx      = busy;
        overflow_nx  = overflow;
        drop_err_nx  = drop_err;

        case (state)
            IDLE, DONE: begin
                if (load_req) begin
                    state_nx    = RECV;
                    byte_cnt_nx = '0;
                    mem_addr_nx = '0;
                    overflow_nx = 1'b0;
                    drop_err_nx = 1'b0;
                    start_nx    = 1'b0;
                    busy_nx     = 1'b1;
                end
            end
            RECV: begin
                if (rx_valid) begin
                    word_nx     = shifted;
                    byte_cnt_nx = byte_cnt + 2'd1;
                    if (byte_cnt == 2'd3) begin
                        state_nx     = WRITE;
                        mem_we_nx    = 1'b1;
                        mem_wdata_nx = shifted;
                    end
                end
            end
            WRITE: begin
                if (rx_valid) begin
                    drop_err_nx = 1'b1;
                end
                if (mem_wdata == HALT_WORD) begin
                    state_nx = DONE;
                    start_nx = 1'b1;
                    busy_nx  = 1'b0;
                end else if (mem_addr == LAST_ADDR) begin
                    state_nx    = DONE;
                    overflow_nx = 1'b1;
                    start_nx    = 1'b1;
                    busy_nx     = 1'b0;
                end else begin
                    state_nx    = RECV;
                    mem_addr_nx = mem_addr + len_addr'(1);
                end
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_instr_loader.sv
// Bench for instr_loader: byte-queue reference model checked every cycle,
// plus directed scenarios with hand-computed write logs and flag values.
module tb_instr_loader;

    localparam int unsigned MAXW = 4;
    localparam logic [31:0] HALT = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        load_req = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        rx_valid = 1'b0;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        start, busy, overflow, drop_err;

    int tests = 0;
    int fails = 0;

    instr_loader #(
        .len_addr (32),
        .len_data (32),
        .MAX_WORDS(MAXW),
        .HALT_WORD(HALT)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .load_req (load_req),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .start    (start),
        .busy     (busy),
        .overflow (overflow),
        .drop_err (drop_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: a loader is either idle, collecting bytes, or has one
    // write pending; words are built from whatever bytes have been collected.
    logic [7:0]  mq[$];
    bit          armed = 0;
    bit          m_loading = 0;
    logic        m_we = 0, m_start = 0, m_busy = 0, m_ovf = 0, m_drop = 0;
    logic [31:0] m_addr = '0, m_wdata = '0;

    always @(posedge clk) begin
        if (reset) begin
            armed = 1;
            m_loading = 0;
            mq.delete();
            m_we = 0; m_addr = '0; m_wdata = '0;
            m_start = 0; m_busy = 0; m_ovf = 0; m_drop = 0;
        end else if (m_we) begin
            if (rx_valid) m_drop = 1;
            m_we = 0;
            if (m_wdata == HALT || m_addr == MAXW - 1) begin
                m_ovf     = m_ovf | (m_wdata != HALT);
                m_loading = 0;
                m_start   = 1;
                m_busy    = 0;
            end else begin
                m_addr = m_addr + 1;
            end
        end else if (!m_loading) begin
            if (load_req) begin
                m_loading = 1;
                mq.delete();
                m_addr = '0; m_ovf = 0; m_drop = 0; m_start = 0; m_busy = 1;
            end
        end else if (rx_valid) begin
            mq.push_back(rx_data);
            if (mq.size() == 4) begin
                m_wdata = {mq[0], mq[1], mq[2], mq[3]};
                mq.delete();
                m_we = 1;
            end
        end
    end

    // Observed write log for the directed checks.
    logic [31:0] wa[$];
    logic [31:0] wd[$];

    // Per-cycle compare against the model, away from the active edge.
    always @(negedge clk) begin
        if (armed) begin
            chk("mem_we",    64'(mem_we),    64'(m_we));
            chk("mem_addr",  64'(mem_addr),  64'(m_addr));
            chk("mem_wdata", 64'(mem_wdata), 64'(m_wdata));
            chk("start",     64'(start),     64'(m_start));
            chk("busy",      64'(busy),      64'(m_busy));
            chk("overflow",  64'(overflow),  64'(m_ovf));
            chk("drop_err",  64'(drop_err),  64'(m_drop));
        end
        if (mem_we === 1'b1) begin
            wa.push_back(mem_addr);
            wd.push_back(mem_wdata);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic put_byte(input logic [7:0] b);
        rx_data = b; rx_valid = 1'b1; load_req = 1'b0;
        cyc();
        rx_valid = 1'b0;
    endtask

    task automatic pulse_load();
        load_req = 1'b1; rx_valid = 1'b0;
        cyc();
        load_req = 1'b0;
    endtask

    // Four bytes MSB first, then one cycle for the write (optionally with a stray byte).
    task automatic send_word(input logic [31:0] w, input bit stray, input logic [7:0] sb);
        for (int unsigned i = 0; i < 4; i++) put_byte(w[8*(3-i) +: 8]);
        if (stray) put_byte(sb);
        else cyc();
    endtask

    task automatic chk_log(input string name, input int idx, input logic [31:0] a, input logic [31:0] d);
        if (idx < wa.size()) chk(name, {wa[idx], wd[idx]}, {a, d});
        else chk(name, 64'hDEAD_0000_0000_0000 | 64'(idx), {a, d});
    endtask

    initial begin
        // Reset state
        cyc(); cyc();
        reset = 1'b0;
        chk("rst_we",    64'(mem_we), 64'd0);
        chk("rst_addr",  64'(mem_addr), 64'd0);
        chk("rst_wdata", 64'(mem_wdata), 64'd0);
        chk("rst_start", 64'(start), 64'd0);
        chk("rst_busy",  64'(busy), 64'd0);
        cyc();

        // Basic program: one word then the halt marker
        wa.delete(); wd.delete();
        pulse_load();
        chk("s1_busy", 64'(busy), 64'd1);
        send_word(32'h2008_0005, 0, 8'h00);
        for (int unsigned i = 0; i < 4; i++) put_byte(8'hFF);
        chk("s1_halt_we",    64'(mem_we), 64'd1);
        chk("s1_halt_start", 64'(start), 64'd0);
        cyc();
        chk("s1_start", 64'(start), 64'd1);
        chk("s1_busy0", 64'(busy), 64'd0);
        chk("s1_nwr",   64'(wa.size()), 64'd2);
        chk_log("s1_w0", 0, 32'd0, 32'h2008_0005);
        chk_log("s1_w1", 1, 32'd1, 32'hFFFF_FFFF);

        // DONE ignores bytes; a new load restarts at address 0
        for (int unsigned i = 0; i < 6; i++) put_byte(8'(8'h40 + i));
        chk("s2_start_held", 64'(start), 64'd1);
        chk("s2_nwr",        64'(wa.size()), 64'd2);
        pulse_load();
        chk("s2_start0", 64'(start), 64'd0);
        chk("s2_busy1",  64'(busy), 64'd1);
        wa.delete(); wd.delete();

        // Stray byte in WRITE, then run into the end of memory
        send_word(32'hDEAD_BEEF, 0, 8'h00);
        send_word(32'h0102_0304, 1, 8'hAB);
        chk("s3_drop", 64'(drop_err), 64'd1);
        send_word(32'h0506_0708, 0, 8'h00);
        send_word(32'h0A0B_0C0D, 0, 8'h00);
        chk("s3_ovf",   64'(overflow), 64'd1);
        chk("s3_start", 64'(start), 64'd1);
        send_word(32'hCAFE_F00D, 0, 8'h00);
        chk("s3_nwr", 64'(wa.size()), 64'd4);
        chk_log("s3_w0", 0, 32'd0, 32'hDEAD_BEEF);
        chk_log("s3_w1", 1, 32'd1, 32'h0102_0304);
        chk_log("s3_w2", 2, 32'd2, 32'h0506_0708);
        chk_log("s3_w3", 3, 32'd3, 32'h0A0B_0C0D);
        chk("s3_drop_sticky", 64'(drop_err), 64'd1);

        // Fresh overflow load: flags cleared, four writes, no fifth
        pulse_load();
        chk("s4_ovf_clr",  64'(overflow), 64'd0);
        chk("s4_drop_clr", 64'(drop_err), 64'd0);
        wa.delete(); wd.delete();
        for (int unsigned i = 0; i < 5; i++) send_word(32'h1020_3040 + i, 0, 8'h00);
        chk("s4_nwr", 64'(wa.size()), 64'd4);
        chk_log("s4_w3", 3, 32'd3, 32'h1020_3043);
        chk("s4_ovf", 64'(overflow), 64'd1);

        // Reset mid-word discards the partial word; load_req mid-word ignored
        pulse_load();
        wa.delete(); wd.delete();
        put_byte(8'h12); put_byte(8'h34);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        chk("s5_we_rst", 64'(mem_we), 64'd0);
        cyc();
        chk("s5_we_after", 64'(mem_we), 64'd0);
        pulse_load();
        put_byte(8'h11); put_byte(8'h22);
        pulse_load();
        put_byte(8'h33); put_byte(8'h44);
        cyc();
        chk("s5_nwr", 64'(wa.size()), 64'd1);
        chk_log("s5_w0", 0, 32'd0, 32'h1122_3344);

        // Reset with simultaneous load_req and rx_valid from DONE
        send_word(HALT, 0, 8'h00);
        chk("s6_start", 64'(start), 64'd1);
        reset = 1'b1; load_req = 1'b1; rx_valid = 1'b1; rx_data = 8'h55;
        cyc();
        reset = 1'b0; load_req = 1'b0; rx_valid = 1'b0;
        chk("s6_outs", {31'd0, mem_we, mem_addr},
            64'd0);
        chk("s6_flags", {28'd0, start, busy, overflow, drop_err, mem_wdata}, 64'd0);
        put_byte(8'h77);
        chk("s6_idle_busy", 64'(busy), 64'd0);
        pulse_load();
        chk("s6_load_busy", 64'(busy), 64'd1);

        cyc(); cyc();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/instr_loader.md
INSTR_LOADER -- requirements
Module: instr_loader

Interface
REQ-001 Parameter len_addr, default 32, width of mem_addr (word address into instruction memory).
REQ-002 Parameter len_data, default 32, instruction word width; fixed at 4 bytes.
REQ-003 Parameter MAX_WORDS, default 1024, instruction memory capacity in words.
REQ-004 Parameter HALT_WORD, default 32'hFFFF_FFFF, end-of-program marker.
REQ-005 clk  input  1  clock; all state changes on posedge clk.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 load_req  input  1  one-cycle pulse; starts a new program load.
REQ-008 rx_data  input  8  byte from UART receiver.
REQ-009 rx_valid  input  1  one-cycle strobe; rx_data valid this cycle.
REQ-010 mem_we  output  1  instruction memory write enable.
REQ-011 mem_addr  output  len_addr  instruction memory word write address.
REQ-012 mem_wdata  output  len_data  assembled instruction word.
REQ-013 start  output  1  program loaded; enables PC and pipeline execution.
REQ-014 busy  output  1  high in RECV or WRITE.
REQ-015 overflow  output  1  sticky; load ended at MAX_WORDS without HALT_WORD.
REQ-016 drop_err  output  1  sticky; a byte arrived while in WRITE and was discarded.

Function
REQ-017 FSM states IDLE, RECV, WRITE, DONE; registered outputs only.
REQ-018 IDLE: load_req -> RECV; clear byte_cnt, mem_addr, overflow, drop_err; rx_valid ignored.
REQ-019 RECV: each rx_valid shifts rx_data into word, MSB first (byte 0 -> bits [31:24]); byte_cnt increments mod 4.
REQ-020 RECV: rx_valid that completes the 4th byte -> WRITE next cycle; byte_cnt returns to 0.
REQ-021 WRITE: exactly one cycle; mem_we=1, mem_wdata=assembled word, mem_addr=current word address.
REQ-022 WRITE, word == HALT_WORD: HALT_WORD is written, then -> DONE; mem_addr not incremented.
REQ-023 WRITE, mem_addr == MAX_WORDS-1 and word != HALT_WORD: write performed, overflow<=1, -> DONE.
REQ-024 WRITE otherwise: mem_addr <= mem_addr+1, -> RECV.
REQ-025 rx_valid during WRITE: byte discarded, drop_err<=1; no state effect otherwise.
REQ-026 mem_we is 0 in every state except WRITE.
REQ-027 DONE: start=1 held; rx_valid ignored; load_req -> RECV with the same clears as REQ-018, start<=0.
REQ-028 load_req in RECV or WRITE: ignored; load continues.
REQ-029 Latency: mem_we asserts the cycle after the 4th-byte strobe; start asserts the cycle after the HALT_WORD write (or the overflow write).
REQ-030 Partial word (byte_cnt != 0) never written; remains pending until completed or reset.
REQ-031 mem_addr counts words; write addresses go 0..MAX_WORDS-1; never wraps.

Reset
REQ-032 reset has priority over all inputs, including simultaneous load_req and rx_valid.
REQ-033 Reset values: state IDLE, mem_we 0, mem_addr 0, mem_wdata 0, start 0, busy 0, overflow 0, drop_err 0, byte_cnt 0.
REQ-034 Reset mid-load: partial word discarded, no write issued in the reset cycle or the cycle after.

Verification
REQ-035 load_req; bytes 20,08,00,05, FF,FF,FF,FF -> writes 0x20080005 @0, 0xFFFFFFFF @1; start=1 one cycle after the second write; busy=0.
REQ-036 MAX_WORDS=4; load_req; 16 bytes, no HALT_WORD -> 4 writes @0..3; overflow=1; start=1; no 5th write.
REQ-037 load_req; bytes 12,34 then reset; then load_req; 11,22,33,44 -> single write 0x11223344 @0; no write of 0x1234xxxx.
REQ-038 Complete a word, rx_valid=AB in the WRITE cycle -> drop_err=1; next word assembled from subsequent bytes only.
REQ-039 In DONE, rx_valid bursts -> no mem_we, start stays 1; then load_req -> start=0, busy=1, next write @0.
REQ-040 reset asserted together with load_req and rx_valid -> all outputs at REQ-033 values next cycle; state IDLE.
